// File: rtl/tx_arbiter_pkg.sv
// tx_arbiter_pkg: shared definitions for the transmit arbiter.
//   PAYLOAD_W        - payload width carried per requester / per frame
//   FRAME_CYCLES_DEF - clocks per transmitter frame (idle, start, data, parity)
//   state_e          - arbiter FSM state encoding
package tx_arbiter_pkg;

  localparam int PAYLOAD_W = 7;

  // One idle bit, one start bit, PAYLOAD_W data bits, one parity bit.
  localparam int FRAME_CYCLES_DEF = 1 + 1 + PAYLOAD_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i    - request vector
//   ptr_i    - highest-priority index
//   winner_o - first asserted request at ptr, ptr+1, ... (mod N_REQ)
//   valid_o  - any request asserted
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  // Rotate so bit 0 is the request at ptr; the lowest set bit then wins.
  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   sum;

  assign rot     = N_REQ'({req_i, req_i} >> ptr_i);
  assign valid_o = |req_i;

  // Scan downwards so the lowest rotated offset is the last (winning) write.
  always_comb begin
    winner_o = '0;
    sum      = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        winner_o = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial transmitter between N_REQ requesters.
//   clk, rstn - clock, async active-low reset
//   req       - per-requester request, held with data stable until ack
//   data_in   - requester i payload in [7i+6:7i]
//   ack       - one-hot pulse, payload of that requester latched
//   tx_start  - one-cycle launch pulse to the transmitter
//   tx_data   - latched payload, stable for the whole frame
//   grant_id  - index of the last granted requester
//   busy      - frame in flight
//   tx_done   - one-cycle pulse when the spacing window closes
// Launches are spaced FRAME_CYCLES apart under continuous load: one launch
// cycle, FRAME_CYCLES-2 countdown cycles, one tx_done cycle back into IDLE.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int FRAME_CYCLES = FRAME_CYCLES_DEF,
  localparam int IDX_W        = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [PAYLOAD_W*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]           ack,
  output logic                       tx_start,
  output logic [PAYLOAD_W-1:0]       tx_data,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       busy,
  output logic                       tx_done
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;
  logic [PAYLOAD_W-1:0] win_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .winner_o(win_idx),
    .valid_o (win_vld)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_idx == IDX_W'(i)) win_data = data_in[i*PAYLOAD_W +: PAYLOAD_W];
  end

  assign ptr_d = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      tx_start <= 1'b0;
      ack      <= '0;
      tx_data  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      tx_done  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // req is only looked at here; changes during WAIT are ignored.
          if (win_vld) begin
            tx_data  <= win_data;
            tx_start <= 1'b1;
            ack      <= N_REQ'(1) << win_idx;
            grant_id <= win_idx;
            busy     <= 1'b1;
            cnt_q    <= CNT_W'(FRAME_CYCLES-2);
            ptr_q    <= ptr_d;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            busy    <= 1'b0;
            tx_done <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one serial transmitter; the block SHALL support 2..8.
REQ-002 Parameter FRAME_CYCLES, default 10: minimum tx_start-to-tx_start spacing in clocks; the block SHALL support values of 3 or more.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  per-requester request; held high with data stable until the matching ack.
REQ-006 data_in  input  7*N_REQ  requester i payload in bits [7i+6:7i].
REQ-007 ack  output  N_REQ  one-hot, one-cycle pulse; the payload of the acked requester has been latched.
REQ-008 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-009 tx_data  output  7  payload presented to the transmitter; stable while busy.
REQ-010 grant_id  output  $clog2(N_REQ)  index of the last granted requester.
REQ-011 busy  output  1  high while a frame is in flight.
REQ-012 tx_done  output  1  one-cycle pulse when the spacing window closes.

Function
REQ-013 The block SHALL implement a 2-state FSM, IDLE and WAIT, plus a down-counter cnt.
REQ-014 In IDLE with any req bit high, on one edge the block SHALL:
- select winner w by round-robin;
- register tx_data = data_in slice w, tx_start = 1, ack = onehot(w), grant_id = w, busy = 1;
- load cnt = FRAME_CYCLES-2;
- go to WAIT.
REQ-015 In IDLE with req all zero, all outputs SHALL hold, and tx_start and ack SHALL be 0.
REQ-016 In WAIT:
- tx_start and ack SHALL be 0;
- if cnt != 0, cnt SHALL decrement;
- if cnt == 0, the block SHALL go to IDLE with busy = 0 and tx_done = 1 for one cycle.
REQ-017 Consecutive tx_start pulses SHALL be at least FRAME_CYCLES clocks apart.
REQ-018 Under continuous requests, consecutive tx_start pulses SHALL be exactly FRAME_CYCLES clocks apart, with tx_done and the next launch in adjacent cycles.
REQ-019 Round-robin rule:
- a pointer ptr SHALL hold the highest-priority index;
- the winner SHALL be the first asserted req at ptr, ptr+1, ... modulo N_REQ;
- after a grant to w, ptr SHALL become (w+1) mod N_REQ.
REQ-020 req SHALL be sampled only in IDLE.
REQ-021 A requester that drops req before being acked SHALL NOT be granted.
REQ-022 req changes during WAIT SHALL have no effect.
REQ-023 A requester that holds req after its ack SHALL be treated as a new request, subject to round-robin.
REQ-024 Each ack SHALL correspond to exactly one tx_start in the same cycle; no payload SHALL be dropped or duplicated.

Reset
REQ-025 While rstn is low, the block SHALL force: state = IDLE, cnt = 0, ptr = 0, tx_start = 0, ack = 0, tx_data = 0, grant_id = 0, busy = 0, tx_done = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without any ack or tx_done pulse.
REQ-027 The first grant after reset release SHALL use ptr = 0.

Structure
REQ-028 A shared package SHALL hold:
- the FSM state encoding;
- the payload width constant (7);
- the FRAME_CYCLES default matching the transmitter frame (idle, start, 7 data bits, parity).
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter: inputs req and ptr, outputs winner index and valid.
REQ-030 tx_arbiter SHALL NOT instantiate the transmitter; the integration top SHALL connect tx_start/tx_data to it, sharing clk and rstn.

Verification
REQ-031 Single request: req[1] = 1 with payload 7'h55 -> in the same cycle ack = 4'b0010, tx_start = 1, tx_data = 7'h55, grant_id = 1; with the transmitter attached, serial line = 0, 1,0,1,0,1,0,1 (LSB first), parity 0.
REQ-032 All four req held high -> grants in order 0,1,2,3,0; tx_start exactly 10 cycles apart; tx_done immediately precedes each launch after the first.
REQ-033 After a grant to 2, req[0] and req[3] rise together -> 3 is granted first, then 0.
REQ-034 req[2] pulses high for 3 cycles during WAIT and drops before IDLE -> no ack[2] and no tx_start.
REQ-035 rstn low at cycle 4 of WAIT -> all outputs 0 in that cycle, no tx_done; after release with req[3] high, grant_id = 3 and ptr afterwards = 0.
